// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-requester ALU sharing block:
// default widths and the ALU operation codes it passes through.
package alu_share_arbiter_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int OPW_DEF   = 4;

   // Operation codes understood by the external ALU. The arbiter never
   // decodes them; they are listed here for users and benches.
   localparam logic [OPW_DEF-1:0] ALU_AND = 4'b0000;
   localparam logic [OPW_DEF-1:0] ALU_OR  = 4'b0001;
   localparam logic [OPW_DEF-1:0] ALU_ADD = 4'b0010;
   localparam logic [OPW_DEF-1:0] ALU_SUB = 4'b0110;
   localparam logic [OPW_DEF-1:0] ALU_SLT = 4'b0111;
   localparam logic [OPW_DEF-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_resp_slot.sv
// One requester's registered result slot. The slot state (EMPTY/FULL) is
// carried by 'valid' itself, which is also the slot's visible status.
module alu_resp_slot
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             zero
);

   // Capture on grant (also covers drain+grant back-to-back), else empty on drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         zero  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= alu_result;
         zero  <= alu_zero;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between the
// integer datapath (requester 0) and the address/branch path (requester 1).
//
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// req_ready may depend on req_valid, but requesters must never make
// req_valid depend on req_ready. A response transfers on a cycle where
// resp_valid && resp_ready; resp_valid stays high and resp_data/resp_zero
// stay stable until that transfer.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_data,
   output logic             resp0_zero,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_data,
   output logic             resp1_zero,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             prio_state
);

   logic prio;
   logic elig0, elig1;
   logic grant0, grant1;

   // A slot being drained this cycle can already take a new operation.
   assign elig0 = req0_valid && (!resp0_valid || resp0_ready);
   assign elig1 = req1_valid && (!resp1_valid || resp1_ready);

   // Lone eligible requester wins; on contention prio picks the winner.
   assign grant0 = elig0 && (!elig1 || !prio);
   assign grant1 = elig1 && (!elig0 ||  prio);

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign prio_state = prio;

   // Steer the granted request to the ALU; park it at zero when idle.
   always_comb begin
      alu_op = '0;
      alu_a  = '0;
      alu_b  = '0;
      if (grant0) begin
         alu_op = req0_op;
         alu_a  = req0_a;
         alu_b  = req0_b;
      end else if (grant1) begin
         alu_op = req1_op;
         alu_a  = req1_a;
         alu_b  = req1_b;
      end
   end

   // Priority passes to the other requester after every grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio <= 1'b0;
      end else if (grant0) begin
         prio <= 1'b1;
      end else if (grant1) begin
         prio <= 1'b0;
      end
   end

   alu_resp_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (grant0),
      .drain      (resp0_ready),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .valid      (resp0_valid),
      .data       (resp0_data),
      .zero       (resp0_zero)
   );

   alu_resp_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (grant1),
      .drain      (resp1_ready),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .valid      (resp1_valid),
      .data       (resp1_data),
      .zero       (resp1_zero)
   );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural external ALU.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        req0_valid, req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        resp0_valid, resp0_ready, resp0_zero;
   logic [31:0] resp0_data;
   logic        req1_valid, req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        resp1_valid, resp1_ready, resp1_zero;
   logic [31:0] resp1_data;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero;
   logic        prio_state;

   int checks;
   int errors;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   alu_share_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_op     (req0_op),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp0_data  (resp0_data),
      .resp0_zero  (resp0_zero),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_op     (req1_op),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp1_data  (resp1_data),
      .resp1_zero  (resp1_zero),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .prio_state  (prio_state)
   );

   // External ALU stand-in; unknown codes give 0.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_SLT: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
         ALU_NOR: alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v;
      req0_op    = op;
      req0_a     = a;
      req0_b     = b;
   endtask

   task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v;
      req1_op    = op;
      req1_a     = a;
      req1_b     = b;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_data;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[11];
   int   n0, n1;
   logic [31:0] exp_v;

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      drive0(1'b0, 4'd0, 32'd0, 32'd0);
      drive1(1'b0, 4'd0, 32'd0, 32'd0);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;

      vecs[0]  = '{ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
      vecs[1]  = '{ALU_SUB, 32'd9,          32'd9,          32'd0,          1'b1};
      vecs[2]  = '{ALU_AND, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0};
      vecs[3]  = '{ALU_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
      vecs[4]  = '{ALU_SLT, 32'd3,          32'd8,          32'd1,          1'b0};
      vecs[5]  = '{ALU_SLT, 32'd8,          32'd3,          32'd0,          1'b1};
      vecs[6]  = '{ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
      vecs[7]  = '{ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
      vecs[8]  = '{ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
      vecs[9]  = '{4'b0011, 32'd6,          32'd6,          32'd0,          1'b1};
      vecs[10] = '{ALU_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_resp0_valid", resp0_valid, 1'b0);
      chk1("rst_resp1_valid", resp1_valid, 1'b0);
      chk("rst_resp0_data", resp0_data, 32'd0);
      chk("rst_resp1_data", resp1_data, 32'd0);
      chk1("rst_resp0_zero", resp0_zero, 1'b0);
      chk1("rst_resp1_zero", resp1_zero, 1'b0);
      chk1("rst_prio", prio_state, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("idle_alu_op", 32'(alu_op), 32'd0);
      chk("idle_alu_a", alu_a, 32'd0);
      chk("idle_alu_b", alu_b, 32'd0);

      // Table of single-requester operations; requester 1 operands are X
      resp0_ready = 1'b1;
      req1_op = 'x;
      req1_a  = 'x;
      req1_b  = 'x;
      for (int i = 0; i < 11; i++) begin
         drive0(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
         #1;
         chk1("vec_req0_ready", req0_ready, 1'b1);
         chk1("vec_req1_ready", req1_ready, 1'b0);
         chk("vec_alu_op", 32'(alu_op), 32'(vecs[i].op));
         chk("vec_alu_a", alu_a, vecs[i].a);
         chk("vec_alu_b", alu_b, vecs[i].b);
         tick();
         chk1("vec_resp0_valid", resp0_valid, 1'b1);
         chk("vec_resp0_data", resp0_data, vecs[i].exp_data);
         chk1("vec_resp0_zero", resp0_zero, vecs[i].exp_zero);
      end

      // Drain without new request: slot empties, data holds, ALU idles
      drive0(1'b0, 4'd0, 32'd0, 32'd0);
      drive1(1'b0, 4'd0, 32'd0, 32'd0);
      #1;
      chk1("drain_req0_ready", req0_ready, 1'b0);
      chk("drain_alu_op", 32'(alu_op), 32'd0);
      chk("drain_alu_a", alu_a, 32'd0);
      tick();
      chk1("drain_resp0_valid", resp0_valid, 1'b0);
      chk("drain_resp0_data_hold", resp0_data, 32'hFFFF_FFFF);

      // Contention right after reset: requester 0 first, then 1
      do_reset();
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      drive0(1'b1, ALU_SUB, 32'd9, 32'd9);
      drive1(1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
      #1;
      chk1("both_req0_ready", req0_ready, 1'b1);
      chk1("both_req1_ready", req1_ready, 1'b0);
      tick();
      chk("both_resp0_data", resp0_data, 32'd0);
      chk1("both_resp0_zero", resp0_zero, 1'b1);
      chk1("both_resp1_valid0", resp1_valid, 1'b0);
      drive0(1'b0, 4'd0, 32'd0, 32'd0);
      #1;
      chk1("both_req1_ready2", req1_ready, 1'b1);
      tick();
      chk1("both_resp1_valid", resp1_valid, 1'b1);
      chk("both_resp1_data", resp1_data, 32'h0000_00FF);
      chk1("both_resp1_zero", resp1_zero, 1'b0);
      chk1("both_resp0_drained", resp0_valid, 1'b0);
      chk1("both_prio_end", prio_state, 1'b0);

      // Continuous contention: strict alternation starting with requester 0
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 8; i++) begin
         drive0(1'b1, ALU_ADD, 32'(i), 32'd100);
         drive1(1'b1, ALU_SUB, 32'd1000, 32'(i));
         #1;
         chk1("alt_req0_ready", req0_ready, (i % 2) == 0);
         chk1("alt_req1_ready", req1_ready, (i % 2) == 1);
         if (req0_ready) begin
            exp_q0.push_back(32'(i + 100));
            n0++;
         end
         if (req1_ready) begin
            exp_q1.push_back(32'(1000 - i));
            n1++;
         end
         tick();
         if ((i % 2) == 0) begin
            chk1("alt_resp0_valid", resp0_valid, 1'b1);
            chk1("alt_resp1_empty", resp1_valid, 1'b0);
            exp_v = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hDEAD_BEEF;
            chk("alt_resp0_data", resp0_data, exp_v);
         end else begin
            chk1("alt_resp1_valid", resp1_valid, 1'b1);
            chk1("alt_resp0_empty", resp0_valid, 1'b0);
            exp_v = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hDEAD_BEEF;
            chk("alt_resp1_data", resp1_data, exp_v);
         end
      end
      chk("alt_count0", 32'(n0), 32'd4);
      chk("alt_count1", 32'(n1), 32'd4);
      chk("alt_q0_left", 32'(exp_q0.size()), 32'd0);
      chk("alt_q1_left", 32'(exp_q1.size()), 32'd0);

      // Requester 1 stalled by a full undrained slot; requester 0 keeps going
      resp1_ready = 1'b0;
      drive1(1'b1, ALU_ADD, 32'd1, 32'd1);
      for (int k = 0; k < 4; k++) begin
         drive0(1'b1, ALU_ADD, 32'(k + 10), 32'd1);
         #1;
         chk1("bp_req1_ready", req1_ready, 1'b0);
         chk1("bp_req0_ready", req0_ready, 1'b1);
         tick();
         chk("bp_resp0_data", resp0_data, 32'(k + 11));
         chk1("bp_resp1_valid", resp1_valid, 1'b1);
         chk("bp_resp1_hold", resp1_data, 32'd993);
      end
      resp1_ready = 1'b1;
      #1;
      chk1("bp_release_req1", req1_ready, 1'b1);
      chk1("bp_release_req0", req0_ready, 1'b0);
      tick();
      chk("bp_release_data", resp1_data, 32'd2);
      chk1("bp_release_valid", resp1_valid, 1'b1);
      chk1("bp_resp0_drained", resp0_valid, 1'b0);

      // Asynchronous reset with both slots full
      resp1_ready = 1'b0;
      resp0_ready = 1'b0;
      drive1(1'b0, 4'd0, 32'd0, 32'd0);
      drive0(1'b1, ALU_AND, 32'h0000_00FF, 32'h0000_000F);
      tick();
      chk1("ar_pre_resp0", resp0_valid, 1'b1);
      chk1("ar_pre_resp1", resp1_valid, 1'b1);
      drive0(1'b0, 4'd0, 32'd0, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk1("ar_resp0_valid", resp0_valid, 1'b0);
      chk1("ar_resp1_valid", resp1_valid, 1'b0);
      chk("ar_resp0_data", resp0_data, 32'd0);
      chk("ar_resp1_data", resp1_data, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      drive0(1'b1, ALU_ADD, 32'd20, 32'd22);
      drive1(1'b1, ALU_ADD, 32'd1, 32'd2);
      #1;
      chk1("ar_first_req0", req0_ready, 1'b1);
      chk1("ar_first_req1", req1_ready, 1'b0);
      tick();
      chk("ar_first_data", resp0_data, 32'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters: requester 0 is the integer datapath and requester 1 is the address/branch-compare path.
- Round-robin arbitration with a valid/ready request handshake.
- The ALU is instantiated outside this block; it drives the ALU's operation and operands and samples its result and zero flag.
- Each requester has its own registered response slot, held until that requester drains it.

Parameters:
- WIDTH, 32, operand/result width (must match the ALU)
- OPW, 4, ALU operation code width

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0's operation is accepted this cycle
- req0_op  in  OPW  ALU operation code
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- resp0_valid  out  1  requester 0 result slot full
- resp0_ready  in  1  requester 0 consumes the result
- resp0_data  out  WIDTH  registered ALU result
- resp0_zero  out  1  registered zero flag
- req1_*, resp1_*  same set as requester 0, for requester 1
- alu_op  out  OPW  operation code to the ALU
- alu_a  out  WIDTH  operand A to the ALU
- alu_b  out  WIDTH  operand B to the ALU
- alu_result  in  WIDTH  ALU result (combinational)
- alu_zero  in  1  ALU zero flag

Behaviour:
- ALU codes passed through unchanged: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (unsigned compare), NOR 1100.
  - Any other code yields result 0, zero 1.
  - The arbiter does not check codes.
- Reset (async assert, sync release): resp0_valid = resp1_valid = 0, resp*_data = 0, resp*_zero = 0, prio = 0.
  - Reset mid-operation discards held results and any grant in that cycle.
- Eligibility: elig_i = req_i_valid && (!resp_i_valid || resp_i_ready).
  - A full slot being drained in the same cycle may accept a new operation.
- Grant (combinational, same cycle):
  - Only one requester eligible: that requester is granted.
  - Both eligible: requester prio is granted.
  - Neither eligible: no grant.
- req_i_ready = grant_i. Ready may depend on valid; requesters must not make valid depend on ready.
- ALU drive:
  - Granted requester's op/a/b go to alu_op/alu_a/alu_b.
  - With no grant, alu_op = 0000 and alu_a = alu_b = 0.
- Priority state prio (1 bit): on any grant to i, prio <= ~i at the next edge. With no grant, prio holds.
- Response registers, at the clock edge:
  - Granted i: resp_i_data <= alu_result, resp_i_zero <= alu_zero, resp_i_valid <= 1.
  - Else if resp_i_ready: resp_i_valid <= 0; data and zero hold.
  - Else: hold.
- Latency: operation accepted at edge N, result visible after edge N. Throughput is one operation per cycle total.
- Per-requester FSM (implicit in resp_i_valid):
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on resp_ready without grant.
  - FULL -> FULL on resp_ready with grant (back-to-back).
- No starvation: with both requesters continuously eligible, grants strictly alternate.
- The response of one requester never blocks the other.
- Outputs unaffected by requester X values while that requester is not granted.

Decomposition:
- Shared package holds:
  - ALU op-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR)
  - WIDTH/OPW defaults
- One natural sub-module: alu_resp_slot, the per-requester result register plus valid/ready logic, instantiated twice.
- Arbitration and the prio flop stay in the top.

Test Plan:
- Reset, then req0 ADD a=5 b=7 with resp0_ready=1 -> req0_ready=1 same cycle; next cycle resp0_valid=1, resp0_data=12, resp0_zero=0; alu_op=0000 and operands 0 when idle.
- Both valid after reset (req0 SUB 9-9, req1 OR 0xF0|0x0F), resp ready=1 -> req0 granted first (data 0, zero 1); req1 granted the following cycle (data 0xFF); prio ends at 0.
- Both valid continuously for 8 cycles, ready held high -> grants alternate 0,1,0,1…, four results per requester.
- resp1_ready=0 with resp1 full, req1 valid, req0 valid -> req1_ready stays 0, req0 keeps being granted every cycle; resp1_data holds; raise resp1_ready -> req1 granted in that same cycle.
- req0 SLT a=3 b=8 then a=8 b=3 -> results 1 then 0, zero 0 then 1.
- Assert reset_n=0 asynchronously while resp0 and resp1 are full -> all resp_valid drop immediately; after release, the first simultaneous request grants requester 0.
